dmem_responder: RTL and testbench

- Responder end of the LSU-to-data-memory request/response protocol.
- Accepts one load or store request at a time from the load/store unit and models a fixed multi-cycle access latency over an internal word-organised data array.
- Commits stores with per-byte write masks and returns a tagged response that the LSU uses to pop its load/store buffer.
- Load sign/zero extension and lane selection stay in the LSU; this block always returns the full aligned 32-bit word.

---
 rtl/dmem_responder.sv | 179 +++++++++++++++++
 tb/tb_dmem_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: responder end of the LSU-to-data-memory protocol.
// Accepts one load or store at a time and models a fixed access latency
// over an internal word-organised array. Stores are committed with
// per-byte write masks. Every request gets a tagged response that carries
// the full aligned 32-bit word for loads and zero for stores.
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   req_valid_i/ready_o   request handshake
//   req_we_i              1 = store, 0 = load
//   req_addr_i            byte address (bits [1:0] ignored)
//   req_wmask_i           store byte enables, bit i -> lane [8i+7:8i]
//   req_wdata_i           store data, already lane-aligned
//   req_tag_i             request id, echoed in the response
//   resp_valid_o/ready_i  response handshake
//   resp_we_o             echo of the request's we
//   resp_rdata_o          load data, 0 for stores
//   resp_tag_o            echo of the request's tag
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | access latency running, counter counts down to 1
// RESP  | response held until the LSU accepts it
module dmem_responder #(
    parameter int DMEM_ADDR_LEN = 8,
    parameter int MEM_LATENCY   = 2,
    parameter int TAG_LEN       = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_we_i,
    input  logic [DMEM_ADDR_LEN-1:0] req_addr_i,
    input  logic [3:0]               req_wmask_i,
    input  logic [31:0]              req_wdata_i,
    input  logic [TAG_LEN-1:0]       req_tag_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic                     resp_we_o,
    output logic [31:0]              resp_rdata_o,
    output logic [TAG_LEN-1:0]       resp_tag_o
);

    localparam int IDX_W = DMEM_ADDR_LEN - 2;
    localparam int WORDS = 1 << IDX_W;
    localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               accept, do_access;

    logic               we_q;
    logic [IDX_W-1:0]   idx_q;
    logic [3:0]         wmask_q;
    logic [31:0]        wdata_q;
    logic [TAG_LEN-1:0] tag_q;

    logic               acc_we;
    logic [IDX_W-1:0]   acc_idx;
    logic [3:0]         acc_wmask;
    logic [31:0]        acc_wdata;
    logic [TAG_LEN-1:0] acc_tag;

    logic [31:0]        mem [WORDS];

    logic               addr_lsb_unused;
    assign addr_lsb_unused = ^req_addr_i[1:0];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_o = 1'b0;
        accept      = 1'b0;
        do_access   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready_o = ~reset_i;
                if (req_valid_i && !reset_i) begin
                    accept = 1'b1;
                    if (MEM_LATENCY == 1) begin
                        // Access happens on the accepting edge itself.
                        do_access = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd1) begin
                    do_access = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign resp_valid_o = (state_q == ST_RESP);

    // With a one-cycle latency the access uses the live request fields,
    // otherwise the fields latched at acceptance.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_we    = req_we_i;
            acc_idx   = req_addr_i[DMEM_ADDR_LEN-1:2];
            acc_wmask = req_wmask_i;
            acc_wdata = req_wdata_i;
            acc_tag   = req_tag_i;
        end else begin
            acc_we    = we_q;
            acc_idx   = idx_q;
            acc_wmask = wmask_q;
            acc_wdata = wdata_q;
            acc_tag   = tag_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            we_q         <= 1'b0;
            idx_q        <= '0;
            wmask_q      <= '0;
            wdata_q      <= '0;
            tag_q        <= '0;
            resp_we_o    <= 1'b0;
            resp_rdata_o <= '0;
            resp_tag_o   <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we_i;
                idx_q   <= req_addr_i[DMEM_ADDR_LEN-1:2];
                wmask_q <= req_wmask_i;
                wdata_q <= req_wdata_i;
                tag_q   <= req_tag_i;
            end
            if (do_access) begin
                resp_we_o    <= acc_we;
                resp_tag_o   <= acc_tag;
                resp_rdata_o <= acc_we ? 32'h0 : mem[acc_idx];
            end
        end
    end

    // Array is not reset; a store whose commit edge coincides with reset
    // is dropped.
    always_ff @(posedge clk_i) begin
        if (do_access && acc_we && !reset_i) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_wmask[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance with MEM_LATENCY=2
    logic        rst, req_valid, req_ready, req_we, resp_valid, resp_ready, resp_we;
    logic [7:0]  req_addr;
    logic [3:0]  req_wmask;
    logic [31:0] req_wdata, resp_rdata;
    logic [1:0]  req_tag, resp_tag;

    // Instance with MEM_LATENCY=1
    logic        rst_1, req_valid_1, req_ready_1, req_we_1, resp_valid_1, resp_ready_1, resp_we_1;
    logic [7:0]  req_addr_1;
    logic [3:0]  req_wmask_1;
    logic [31:0] req_wdata_1, resp_rdata_1;
    logic [1:0]  req_tag_1, resp_tag_1;

    dmem_responder #(.DMEM_ADDR_LEN(8), .MEM_LATENCY(2), .TAG_LEN(2)) dut (
        .clk_i(clk), .reset_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wmask_i(req_wmask), .req_wdata_i(req_wdata),
        .req_tag_i(req_tag),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_we_o(resp_we),
        .resp_rdata_o(resp_rdata), .resp_tag_o(resp_tag)
    );

    dmem_responder #(.DMEM_ADDR_LEN(8), .MEM_LATENCY(1), .TAG_LEN(2)) dut1 (
        .clk_i(clk), .reset_i(rst_1),
        .req_valid_i(req_valid_1), .req_ready_o(req_ready_1), .req_we_i(req_we_1),
        .req_addr_i(req_addr_1), .req_wmask_i(req_wmask_1), .req_wdata_i(req_wdata_1),
        .req_tag_i(req_tag_1),
        .resp_valid_o(resp_valid_1), .resp_ready_i(resp_ready_1), .resp_we_o(resp_we_1),
        .resp_rdata_o(resp_rdata_1), .resp_tag_o(resp_tag_1)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the latency-2 instance with resp_ready high.
    task automatic xact(input logic we, input logic [7:0] addr, input logic [3:0] wmask,
                        input logic [31:0] wdata, input logic [1:0] tag,
                        output logic [31:0] rdata, output logic [1:0] rtag,
                        output logic rwe, output int lat);
        int n;
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wmask  = wmask;
        req_wdata  = wdata;
        req_tag    = tag;
        resp_ready = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (n >= 20) lat = 99;
        rdata = resp_rdata;
        rtag  = resp_tag;
        rwe   = resp_we;
        tick();
    endtask

    task automatic store(input string name, input logic [7:0] addr, input logic [3:0] wmask,
                         input logic [31:0] wdata);
        logic [31:0] rd;
        logic [1:0]  tg;
        logic        w;
        int          lat;
        xact(1'b1, addr, wmask, wdata, 2'd0, rd, tg, w, lat);
        chk({name, "_lat"}, 32'(lat), 32'd2);
    endtask

    task automatic load(input string name, input logic [7:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic [1:0]  tg;
        logic        w;
        int          lat;
        xact(1'b0, addr, 4'h0, 32'h0, 2'd2, rd, tg, w, lat);
        chk({name, "_rdata"}, rd, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  tg;
        logic        w;
        int          lat;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wmask = '0;
        req_wdata = '0; req_tag = '0; resp_ready = 1'b1;
        rst_1 = 1'b1; req_valid_1 = 1'b0; req_we_1 = 1'b0; req_addr_1 = '0; req_wmask_1 = '0;
        req_wdata_1 = '0; req_tag_1 = '0; resp_ready_1 = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_tag", 32'(resp_tag), 32'd0);
        chk("rst_we", 32'(resp_we), 32'd0);
        rst = 1'b0;
        rst_1 = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        // Store then load
        xact(1'b1, 8'h10, 4'hF, 32'hDEADBEEF, 2'd1, rd, tg, w, lat);
        chk("st_lat", 32'(lat), 32'd2);
        chk("st_tag", 32'(tg), 32'd1);
        chk("st_we", 32'(w), 32'd1);
        chk("st_rdata", rd, 32'h0);
        xact(1'b0, 8'h13, 4'h0, 32'h0, 2'd2, rd, tg, w, lat);
        chk("ld_lat", 32'(lat), 32'd2);
        chk("ld_tag", 32'(tg), 32'd2);
        chk("ld_we", 32'(w), 32'd0);
        chk("ld_rdata", rd, 32'hDEADBEEF);

        // Partial store and empty-mask store
        store("p_full", 8'h20, 4'hF, 32'h11223344);
        store("p_lane2", 8'h20, 4'b0100, 32'h00AB0000);
        load("p_ld", 8'h20, 32'h11AB3344);
        store("p_none", 8'h20, 4'b0000, 32'hFFFFFFFF);
        load("p_none_ld", 8'h20, 32'h11AB3344);

        // Backpressure with a second request held on req_valid
        store("bp_pre", 8'h40, 4'hF, 32'h0BADF00D);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h40; req_tag = 2'd3;
        resp_ready = 1'b0;
        tick();
        req_addr = 8'h10; req_tag = 2'd0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(resp_valid), 32'd1);
            chk("bp_rdata", resp_rdata, 32'h0BADF00D);
            chk("bp_tag", 32'(resp_tag), 32'd3);
            chk("bp_ready", 32'(req_ready), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_ready_hs", 32'(req_ready), 32'd0);
        tick();
        chk("bp_after_valid", 32'(resp_valid), 32'd0);
        chk("bp_after_ready", 32'(req_ready), 32'd1);
        tick();
        chk("bp_2nd_taken", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
        tick();
        chk("bp_2nd_valid", 32'(resp_valid), 32'd1);
        chk("bp_2nd_rdata", resp_rdata, 32'hDEADBEEF);
        chk("bp_2nd_tag", 32'(resp_tag), 32'd0);
        tick();

        // Reset during WAIT drops the store
        store("rw_pre", 8'h30, 4'hF, 32'h01020304);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h30; req_wmask = 4'hF;
        req_wdata = 32'hCAFEF00D; req_tag = 2'd1;
        tick();
        req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rw_valid", 32'(resp_valid), 32'd0);
        chk("rw_ready", 32'(req_ready), 32'd1);
        load("rw_ld", 8'h30, 32'h01020304);

        // Reset during RESP keeps the committed store
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h34; req_wmask = 4'hF;
        req_wdata = 32'h77778888; req_tag = 2'd1; resp_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        tick();
        chk("rr_in_resp", 32'(resp_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        resp_ready = 1'b1;
        #1;
        chk("rr_valid", 32'(resp_valid), 32'd0);
        load("rr_ld", 8'h34, 32'h77778888);

        // Address wrap at the top of the array
        store("wr_w0", 8'h00, 4'hF, 32'h00000A00);
        store("wr_w1", 8'h04, 4'hF, 32'h00000B04);
        store("wr_top", 8'hFC, 4'hF, 32'h5A5A5A5A);
        load("wr_ld_ff", 8'hFF, 32'h5A5A5A5A);
        load("wr_ld_00", 8'h00, 32'h00000A00);
        load("wr_ld_04", 8'h04, 32'h00000B04);

        // MEM_LATENCY=1: back-to-back every 2 cycles, tags in order
        req_valid_1 = 1'b1;
        resp_ready_1 = 1'b1;
        for (int t = 0; t < 4; t++) begin
            req_we_1    = (t == 0);
            req_addr_1  = 8'h08;
            req_wmask_1 = 4'hF;
            req_wdata_1 = 32'h600DCAFE;
            req_tag_1   = 2'(t);
            #1;
            chk("l1_ready", 32'(req_ready_1), 32'd1);
            tick();
            chk("l1_valid", 32'(resp_valid_1), 32'd1);
            chk("l1_tag", 32'(resp_tag_1), 32'(t));
            chk("l1_rdata", resp_rdata_1, (t == 0) ? 32'h0 : 32'h600DCAFE);
            chk("l1_busy", 32'(req_ready_1), 32'd0);
            tick();
            chk("l1_done", 32'(resp_valid_1), 32'd0);
        end
        req_valid_1 = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
